// File: rtl/main_alu_decoder_pkg.sv
`default_nettype none
// ============================================================================
// main_alu_decoder_pkg : opcode, aluop, ALUControl and funct7 encodings
// Revision: 1.0
// ============================================================================
package main_alu_decoder_pkg;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   localparam logic [1:0] ALUOP_MEM = 2'b00;
   localparam logic [1:0] ALUOP_UNU = 2'b01;
   localparam logic [1:0] ALUOP_R   = 2'b10;
   localparam logic [1:0] ALUOP_IMM = 2'b11;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_MUL = 3'b011;

   localparam logic [6:0] F7_ADD = 7'b0000000;
   localparam logic [6:0] F7_SUB = 7'b0100000;
   localparam logic [6:0] F7_MUL = 7'b0000001;

   localparam logic [2:0] F3_BYTE = 3'b000;

   // Control bits that travel past the E stage
   typedef struct packed {
      logic regwrite;
      logic memwrite;
      logic load;
      logic byte_acc;
      logic memtoreg;
   } mem_ctrl_t;

   typedef struct packed {
      logic regwrite;
      logic load;
      logic byte_acc;
      logic memtoreg;
   } wb_ctrl_t;

endpackage : main_alu_decoder_pkg
`default_nettype wire

// File: rtl/main_alu_decoder_alu_ctrl_decoder.sv
`default_nettype none
// ============================================================================
// alu_ctrl_decoder : combinational aluop/funct7 -> 3-bit ALUControl map
// Revision: 1.0
// ============================================================================
module alu_ctrl_decoder
   import main_alu_decoder_pkg::*;
(
   input  logic [1:0] aluop_i,
   input  logic [6:0] funct7_i,
   output logic [2:0] alu_ctrl_o
);

   always_comb begin
      alu_ctrl_o = ALU_ADD;
      if (aluop_i == ALUOP_R) begin
         // Unknown or unsupported funct7 falls back to add
         case (funct7_i)
            F7_SUB:  alu_ctrl_o = ALU_SUB;
            F7_MUL:  alu_ctrl_o = ALU_MUL;
            default: alu_ctrl_o = ALU_ADD;
         endcase
      end
   end

endmodule : alu_ctrl_decoder
`default_nettype wire

// File: rtl/main_alu_decoder.sv
`default_nettype none
// ============================================================================
// main_alu_decoder : D-stage control decode, pipelined through E/M/W
// Revision: 1.0
// ============================================================================
module main_alu_decoder
   import main_alu_decoder_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       ihit,
   input  logic       dhit,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   output logic       LoadD,
   output logic       ByteD,
   output logic       ALUSrcE,
   output logic [2:0] ALUControl,
   output logic       MemWrite,
   output logic       LoadW,
   output logic       ByteW,
   output logic       MemtoRegW,
   output logic       RegWrite
);

   mem_ctrl_t  ctrl_d;
   logic       alusrc_d;
   logic [1:0] aluop_d;
   logic [2:0] aluctl_d;
   logic       advance;

   mem_ctrl_t  e_ctrl_q;
   logic       e_alusrc_q;
   logic [2:0] e_aluctl_q;
   mem_ctrl_t  m_ctrl_q;
   wb_ctrl_t   w_ctrl_q;

   assign advance = ihit & dhit;

   // X or unsupported opcodes miss every case item and decode to a NOP
   always_comb begin
      ctrl_d   = '0;
      alusrc_d = 1'b0;
      aluop_d  = ALUOP_MEM;
      case (opcode)
         OP_R: begin
            ctrl_d.regwrite = 1'b1;
            aluop_d         = ALUOP_R;
         end
         OP_IMM: begin
            ctrl_d.regwrite = 1'b1;
            alusrc_d        = 1'b1;
            aluop_d         = ALUOP_IMM;
         end
         OP_LOAD: begin
            ctrl_d.load     = 1'b1;
            ctrl_d.regwrite = 1'b1;
            ctrl_d.memtoreg = 1'b1;
            alusrc_d        = 1'b1;
         end
         OP_STORE: begin
            ctrl_d.memwrite = 1'b1;
            alusrc_d        = 1'b1;
         end
         default: ;
      endcase
      if (ctrl_d.load || ctrl_d.memwrite) begin
         case (funct3)
            F3_BYTE: ctrl_d.byte_acc = 1'b1;
            default: ctrl_d.byte_acc = 1'b0;
         endcase
      end
   end

   alu_ctrl_decoder u_alu_ctrl (
      .aluop_i    (aluop_d),
      .funct7_i   (funct7),
      .alu_ctrl_o (aluctl_d)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         e_ctrl_q   <= '0;
         e_alusrc_q <= 1'b0;
         e_aluctl_q <= '0;
         m_ctrl_q   <= '0;
         w_ctrl_q   <= '0;
      end else if (advance) begin
         e_ctrl_q   <= ctrl_d;
         e_alusrc_q <= alusrc_d;
         e_aluctl_q <= aluctl_d;
         m_ctrl_q   <= e_ctrl_q;
         w_ctrl_q   <= '{regwrite: m_ctrl_q.regwrite,
                         load:     m_ctrl_q.load,
                         byte_acc: m_ctrl_q.byte_acc,
                         memtoreg: m_ctrl_q.memtoreg};
      end
   end

   assign LoadD      = ctrl_d.load;
   assign ByteD      = ctrl_d.byte_acc;
   assign ALUSrcE    = e_alusrc_q;
   assign ALUControl = e_aluctl_q;
   assign MemWrite   = m_ctrl_q.memwrite;
   assign LoadW      = w_ctrl_q.load;
   assign ByteW      = w_ctrl_q.byte_acc;
   assign MemtoRegW  = w_ctrl_q.memtoreg;
   assign RegWrite   = w_ctrl_q.regwrite;

endmodule : main_alu_decoder
`default_nettype wire

// File: tb/tb_main_alu_decoder.sv
`default_nettype none
// ============================================================================
// tb_main_alu_decoder : directed vectors with hand-computed expectations
// Revision: 1.0
// ============================================================================
module tb_main_alu_decoder;

   logic       clk = 1'b0;
   logic       reset, ihit, dhit;
   logic [6:0] opcode, funct7;
   logic [2:0] funct3;
   logic       LoadD, ByteD, ALUSrcE, MemWrite, LoadW, ByteW, MemtoRegW, RegWrite;
   logic [2:0] ALUControl;

   int n_tests = 0;
   int n_fail  = 0;

   main_alu_decoder dut (
      .clk        (clk),
      .reset      (reset),
      .ihit       (ihit),
      .dhit       (dhit),
      .opcode     (opcode),
      .funct3     (funct3),
      .funct7     (funct7),
      .LoadD      (LoadD),
      .ByteD      (ByteD),
      .ALUSrcE    (ALUSrcE),
      .ALUControl (ALUControl),
      .MemWrite   (MemWrite),
      .LoadW      (LoadW),
      .ByteW      (ByteW),
      .MemtoRegW  (MemtoRegW),
      .RegWrite   (RegWrite)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      n_tests++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Inputs change #1 after the rising edge; outputs are checked in that window
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
      opcode = op;
      funct3 = f3;
      funct7 = f7;
      #1;
   endtask

   task automatic chk_w(input string tag, input logic [3:0] exp_lbmr);
      chk({tag, "_LoadW"},     8'(LoadW),     8'(exp_lbmr[3]));
      chk({tag, "_ByteW"},     8'(ByteW),     8'(exp_lbmr[2]));
      chk({tag, "_MemtoRegW"}, 8'(MemtoRegW), 8'(exp_lbmr[1]));
      chk({tag, "_RegWrite"},  8'(RegWrite),  8'(exp_lbmr[0]));
   endtask

   localparam logic [6:0] NOP = 7'b0000000;

   initial begin
      reset = 1'b0; ihit = 1'b1; dhit = 1'b1;
      drive(7'b0110011, 3'b000, 7'b0000000);

      // Reset held two cycles with an R-type in D
      tick(); tick();
      chk("rst_ALUSrcE", 8'(ALUSrcE), 8'd0);
      chk("rst_ALUControl", 8'(ALUControl), 8'd0);
      chk("rst_MemWrite", 8'(MemWrite), 8'd0);
      chk_w("rst", 4'b0000);
      chk("rst_LoadD", 8'(LoadD), 8'd0);
      reset = 1'b1;
      drive(NOP, 3'b000, 7'd0);
      tick(); tick(); tick();

      // R-type add / sub / mul back to back
      drive(7'b0110011, 3'b000, 7'b0000000);
      tick();
      drive(7'b0110011, 3'b000, 7'b0100000);
      chk("add_ALUControl", 8'(ALUControl), 8'b010);
      chk("add_ALUSrcE", 8'(ALUSrcE), 8'd0);
      tick();
      drive(7'b0110011, 3'b000, 7'b0000001);
      chk("sub_ALUControl", 8'(ALUControl), 8'b110);
      tick();
      drive(NOP, 3'b000, 7'd0);
      chk("mul_ALUControl", 8'(ALUControl), 8'b011);
      chk("mul_ALUSrcE", 8'(ALUSrcE), 8'd0);
      chk_w("add_w", 4'b0001);
      tick(); tick(); tick();

      // lb
      drive(7'b0000011, 3'b000, 7'd0);
      chk("lb_LoadD", 8'(LoadD), 8'd1);
      chk("lb_ByteD", 8'(ByteD), 8'd1);
      tick();
      drive(NOP, 3'b000, 7'd0);
      chk("lb_ALUSrcE", 8'(ALUSrcE), 8'd1);
      chk("lb_ALUControl", 8'(ALUControl), 8'b010);
      tick();
      chk("lb_MemWrite", 8'(MemWrite), 8'd0);
      tick();
      chk_w("lb_w", 4'b1111);

      // lw
      drive(7'b0000011, 3'b010, 7'd0);
      chk("lw_LoadD", 8'(LoadD), 8'd1);
      chk("lw_ByteD", 8'(ByteD), 8'd0);
      tick();
      drive(NOP, 3'b000, 7'd0);
      tick(); tick();
      chk_w("lw_w", 4'b1011);

      // sw
      drive(7'b0100011, 3'b010, 7'd0);
      chk("sw_LoadD", 8'(LoadD), 8'd0);
      tick();
      drive(NOP, 3'b000, 7'd0);
      chk("sw_ALUSrcE", 8'(ALUSrcE), 8'd1);
      tick();
      chk("sw_MemWrite", 8'(MemWrite), 8'd1);
      tick();
      chk("sw_MemWrite_gone", 8'(MemWrite), 8'd0);
      chk_w("sw_w", 4'b0000);

      // OP-IMM uses the immediate operand
      drive(7'b0010011, 3'b000, 7'b0100000);
      tick();
      drive(NOP, 3'b000, 7'd0);
      chk("imm_ALUSrcE", 8'(ALUSrcE), 8'd1);
      chk("imm_ALUControl", 8'(ALUControl), 8'b010);
      tick(); tick();
      chk_w("imm_w", 4'b0001);

      // Unknown opcode -> bubble
      drive(7'b1111111, 3'b000, 7'b0100000);
      chk("unk_LoadD", 8'(LoadD), 8'd0);
      chk("unk_ByteD", 8'(ByteD), 8'd0);
      tick();
      drive(NOP, 3'b000, 7'd0);
      chk("unk_ALUSrcE", 8'(ALUSrcE), 8'd0);
      chk("unk_ALUControl", 8'(ALUControl), 8'b010);
      tick();
      chk("unk_MemWrite", 8'(MemWrite), 8'd0);
      tick();
      chk_w("unk_w", 4'b0000);

      // Stall on dhit, then on ihit: lb reaches W two cycles late
      for (int s = 0; s < 2; s++) begin
         drive(7'b0000011, 3'b000, 7'd0);
         tick();
         drive(NOP, 3'b000, 7'd0);
         if (s == 0) dhit = 1'b0; else ihit = 1'b0;
         for (int k = 0; k < 2; k++) begin
            drive(7'b0000011, 3'b000, 7'd0);
            chk("stall_LoadD_follows", 8'(LoadD), 8'd1);
            drive(NOP, 3'b000, 7'd0);
            tick();
            chk("stall_ALUSrcE", 8'(ALUSrcE), 8'd1);
            chk("stall_MemWrite", 8'(MemWrite), 8'd0);
            chk_w("stall_w", 4'b0000);
         end
         dhit = 1'b1; ihit = 1'b1;
         #1;
         tick();
         chk("stall_rel_ALUSrcE", 8'(ALUSrcE), 8'd0);
         chk_w("stall_rel_w", 4'b0000);
         tick();
         chk_w("stall_lb_w", 4'b1111);
         tick();
      end

      // Reset mid-flight with a store in M and a load in E, while stalled
      drive(7'b0100011, 3'b000, 7'd0);
      tick();
      drive(7'b0000011, 3'b000, 7'd0);
      tick();
      drive(NOP, 3'b000, 7'd0);
      chk("mf_MemWrite_pre", 8'(MemWrite), 8'd1);
      chk("mf_ALUSrcE_pre", 8'(ALUSrcE), 8'd1);
      reset = 1'b0; dhit = 1'b0;
      #1;
      tick();
      chk("mf_MemWrite", 8'(MemWrite), 8'd0);
      chk("mf_ALUSrcE", 8'(ALUSrcE), 8'd0);
      chk("mf_ALUControl", 8'(ALUControl), 8'd0);
      chk_w("mf_w", 4'b0000);
      reset = 1'b1; dhit = 1'b1;
      #1;
      tick();
      chk("mf_MemWrite_after", 8'(MemWrite), 8'd0);
      chk_w("mf_w1", 4'b0000);
      tick();
      chk_w("mf_w2", 4'b0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_main_alu_decoder
`default_nettype wire
